// File: rtl/seq_controller.sv
// Multi-cycle processor control unit: program counter, instruction register and main FSM
// with conditional/unconditional jumps, data-memory ready handshake and sticky halt.
//
// state    | meaning
// ---------+-------------------------------------------------------
// INIT     | clear pc, start fetching
// FETCH    | ROM samples pc_addr at the closing edge
// LATCH    | capture rom_data into ir, advance pc
// DECODE   | dispatch on opcode (zero_flag sampled here for JPZ)
// LOAD_A   | data memory read, wait for d_ready
// LOAD_B   | write memory data into register file
// STORE    | data memory write, wait for d_ready
// ADD      | ALU add, write result
// SUB      | ALU subtract, write result
// HALT     | frozen until reset
// JUMP     | load pc with jump target

module seq_controller #(
    parameter int IW  = 16,
    parameter int PCW = 7,
    parameter int DAW = 8,
    parameter int RAW = 4
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic [IW-1:0]  rom_data,
    input  logic           zero_flag,
    input  logic           d_ready,
    output logic [PCW-1:0] pc_addr,
    output logic [IW-1:0]  ir_data,
    output logic [DAW-1:0] d_addr,
    output logic           d_w,
    output logic           d_rd,
    output logic           rf_s,
    output logic [RAW-1:0] rf_w_addr,
    output logic           rf_w_en,
    output logic [RAW-1:0] rf_ra_addr,
    output logic [RAW-1:0] rf_rb_addr,
    output logic [2:0]     alu_s,
    output logic [3:0]     state,
    output logic           halted
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_LATCH  = 4'd2,
        S_DECODE = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_JPZ   = 4'd7;

    localparam logic [PCW-1:0] PC_ONE = PCW'(1);

    state_t         state_q;
    state_t         state_d;
    logic [PCW-1:0] pc_q;
    logic [IW-1:0]  ir_q;
    logic [3:0]     opcode;

    assign opcode = ir_q[IW-1:IW-4];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // pc wraps naturally at 2^PCW; HALT leaves both registers untouched
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            case (state_q)
                S_INIT:  pc_q <= '0;
                S_LATCH: begin
                    ir_q <= rom_data;
                    pc_q <= pc_q + PC_ONE;
                end
                S_JUMP:  pc_q <= ir_q[PCW-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH:  state_d = S_LATCH;
            S_LATCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    OP_JMP:   state_d = S_JUMP;
                    OP_JPZ:   state_d = zero_flag ? S_JUMP : S_FETCH;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_STORE:  state_d = d_ready ? S_FETCH : S_STORE;
            S_LOAD_A: state_d = d_ready ? S_LOAD_B : S_LOAD_A;
            S_LOAD_B: state_d = S_FETCH;
            S_ADD:    state_d = S_FETCH;
            S_SUB:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_INIT;
        endcase
    end

    always_comb begin
        d_w     = 1'b0;
        d_rd    = 1'b0;
        rf_s    = 1'b0;
        rf_w_en = 1'b0;
        alu_s   = 3'd0;
        halted  = 1'b0;
        case (state_q)
            S_STORE:  d_w = 1'b1;
            S_LOAD_A: begin
                d_rd = 1'b1;
                rf_s = 1'b1;
            end
            S_LOAD_B: begin
                rf_s    = 1'b1;
                rf_w_en = 1'b1;
            end
            S_ADD: begin
                alu_s   = 3'd1;
                rf_w_en = 1'b1;
            end
            S_SUB: begin
                alu_s   = 3'd2;
                rf_w_en = 1'b1;
            end
            S_HALT:   halted = 1'b1;
            default: ;
        endcase
    end

    // Operand fields depend only on the latched instruction
    always_comb begin
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        rf_w_addr  = '0;
        d_addr     = '0;
        case (opcode)
            OP_STORE: begin
                d_addr     = ir_q[DAW-1:0];
                rf_ra_addr = ir_q[DAW+RAW-1:DAW];
            end
            OP_LOAD: begin
                d_addr    = ir_q[DAW+RAW-1:RAW];
                rf_w_addr = ir_q[RAW-1:0];
            end
            OP_ADD, OP_SUB: begin
                rf_ra_addr = ir_q[3*RAW-1:2*RAW];
                rf_rb_addr = ir_q[2*RAW-1:RAW];
                rf_w_addr  = ir_q[RAW-1:0];
            end
            default: ;
        endcase
    end

    assign pc_addr = pc_q;
    assign ir_data = ir_q;
    assign state   = state_q;

endmodule
